// File: rtl/zbt_data_io.sv
// Data-path I/O for a ZBT SRAM: write data pipeline to the pad, fixed-latency read capture.
// Define ZBT_PARITY_EN to generate per-lane even parity on writes and check it on reads.
module zbt_data_io #(
    parameter int DATA_BITS = 36,
    parameter int RD_LAT    = 4
) (
    input  logic                 fpga_clk,
    input  logic                 fpga_rst_n,
    input  logic                 ui_cmd_valid,
    input  logic                 ui_cmd_we,
    input  logic [DATA_BITS-1:0] ui_wr_data,
    output logic [DATA_BITS-1:0] ui_rd_data,
    output logic                 ui_rd_valid,
    output logic                 ui_par_err,
    output logic [2:0]           rd_pending,
    output logic                 sram_we_n,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_oe_n,
    input  logic [DATA_BITS-1:0] data_in
);

    logic                 sram_we_n_q;
    logic [1:0]           wr_v_q;
    logic [DATA_BITS-1:0] wr_d1_q, wr_d2_q;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 data_oe_n_q;
    logic [RD_LAT-1:0]    rd_sr_q;
    logic                 rd_valid_q;
    logic [DATA_BITS-1:0] rd_data_q;
    logic                 par_err_q, par_err_d;
    logic [2:0]           rd_pending_q, rd_pending_d;

    logic cmd_wr, cmd_rd, rd_ret;

    assign cmd_wr = ui_cmd_valid & ui_cmd_we;
    assign cmd_rd = ui_cmd_valid & ~ui_cmd_we;
    // The oldest read flag marks the edge at which the SRAM data is on data_in.
    assign rd_ret = rd_sr_q[RD_LAT-1];

`ifdef ZBT_PARITY_EN
    localparam int LANES = DATA_BITS / 9;

    always_comb begin
        logic bad;
        data_out_d = wr_d2_q;
        bad        = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            data_out_d[9*l+8] = ^wr_d2_q[9*l +: 8];
            bad = bad | (^data_in[9*l +: 9]);
        end
        par_err_d = rd_ret & bad;
    end
`else
    always_comb begin
        data_out_d = wr_d2_q;
        par_err_d  = 1'b0;
    end
`endif

    // Saturating counter: simultaneous accept and return leave it unchanged.
    always_comb begin
        rd_pending_d = rd_pending_q;
        if (cmd_rd && !rd_ret && rd_pending_q != 3'd4)
            rd_pending_d = rd_pending_q + 3'd1;
        else if (!cmd_rd && rd_ret && rd_pending_q != 3'd0)
            rd_pending_d = rd_pending_q - 3'd1;
    end

    always_ff @(posedge fpga_clk) begin
        if (!fpga_rst_n) begin
            sram_we_n_q  <= 1'b1;
            wr_v_q       <= 2'b00;
            wr_d1_q      <= '0;
            wr_d2_q      <= '0;
            data_out_q   <= '0;
            data_oe_n_q  <= 1'b1;
            rd_sr_q      <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            par_err_q    <= 1'b0;
            rd_pending_q <= 3'd0;
        end else begin
            sram_we_n_q <= ~cmd_wr;
            wr_v_q      <= {wr_v_q[0], cmd_wr};
            wr_d1_q     <= ui_wr_data;
            wr_d2_q     <= wr_d1_q;
            if (wr_v_q[1]) begin
                data_out_q  <= data_out_d;
                data_oe_n_q <= 1'b0;
            end else begin
                data_oe_n_q <= 1'b1;
            end
            rd_sr_q    <= {rd_sr_q[RD_LAT-2:0], cmd_rd};
            rd_valid_q <= rd_ret;
            if (rd_ret)
                rd_data_q <= data_in;
            par_err_q    <= par_err_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    assign sram_we_n   = sram_we_n_q;
    assign data_out    = data_out_q;
    assign data_oe_n   = data_oe_n_q;
    assign ui_rd_data  = rd_data_q;
    assign ui_rd_valid = rd_valid_q;
    assign ui_par_err  = par_err_q;
    assign rd_pending  = rd_pending_q;

endmodule

// File: tb/tb_zbt_data_io.sv
// Bench for zbt_data_io: directed commands, a behavioural ZBT SRAM, and a queue-based scoreboard.
// Build with ZBT_PARITY_EN defined to exercise the parity variant.
module tb_zbt_data_io;

    localparam int W = 36;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid, cmd_we;
    logic [W-1:0] wr_data;
    logic [W-1:0] rd_data;
    logic         rd_valid, par_err;
    logic [2:0]   rd_pending;
    logic         sram_we_n;
    logic [W-1:0] data_out;
    logic         data_oe_n;
    logic [W-1:0] data_in;

    zbt_data_io #(.DATA_BITS(W), .RD_LAT(4)) dut (
        .fpga_clk    (clk),
        .fpga_rst_n  (rst_n),
        .ui_cmd_valid(cmd_valid),
        .ui_cmd_we   (cmd_we),
        .ui_wr_data  (wr_data),
        .ui_rd_data  (rd_data),
        .ui_rd_valid (rd_valid),
        .ui_par_err  (par_err),
        .rd_pending  (rd_pending),
        .sram_we_n   (sram_we_n),
        .data_out    (data_out),
        .data_oe_n   (data_oe_n),
        .data_in     (data_in)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    bit mon_en = 0;

    logic [W-1:0] exp_wr_q[$];
    int           exp_wr_edge_q[$];
    logic [W-1:0] exp_rd_q[$];
    int           exp_rd_edge_q[$];
    logic         exp_pe_q[$];

    logic [W-1:0] mem[int];
    int           wr_addr_q[$];
    int           rd_addr_at[int];
    logic [W-1:0] rd_flip_at[int];
    bit           ret_due[int];

    logic         exp_we_n = 1'b1;
    int           pend_m = 0;
    logic [W-1:0] last_dout = '0;
    logic [W-1:0] last_rd = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_store(input logic [W-1:0] d);
        logic [W-1:0] r;
        r = d;
`ifdef ZBT_PARITY_EN
        for (int l = 0; l < W / 9; l++) r[9*l+8] = ^d[9*l +: 8];
`endif
        return r;
    endfunction

    function automatic logic lane_bad(input logic [W-1:0] d);
        logic b;
        b = 1'b0;
`ifdef ZBT_PARITY_EN
        for (int l = 0; l < W / 9; l++) b = b | (^d[9*l +: 9]);
`endif
        return b;
    endfunction

    // Reference model state that advances on each rising edge.
    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (!rst_n) begin
            pend_m    = 0;
            exp_we_n  = 1'b1;
            last_dout = '0;
            last_rd   = '0;
            exp_wr_q.delete();
            exp_wr_edge_q.delete();
            exp_rd_q.delete();
            exp_rd_edge_q.delete();
            exp_pe_q.delete();
            wr_addr_q.delete();
            rd_addr_at.delete();
            rd_flip_at.delete();
            ret_due.delete();
        end else begin
            bit inc, dec;
            exp_we_n = !(cmd_valid && cmd_we);
            inc = cmd_valid && !cmd_we;
            dec = ret_due.exists(edge_n);
            if (inc && !dec && pend_m < 4) pend_m = pend_m + 1;
            else if (dec && !inc && pend_m > 0) pend_m = pend_m - 1;
        end
    end

    // ZBT SRAM model: commits driven writes, presents read data just before the capture edge.
    always @(negedge clk) begin
        int nxt;
        logic [63:0] r;
        if (data_oe_n === 1'b0 && wr_addr_q.size() > 0)
            mem[wr_addr_q.pop_front()] = data_out;
        nxt = edge_n + 1;
        if (rd_addr_at.exists(nxt)) begin
            data_in = mem[rd_addr_at[nxt]] ^ rd_flip_at[nxt];
        end else begin
            r = {$urandom, $urandom};
            data_in = r[W-1:0];
        end
    end

    // Monitor: compares every observable output once per cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("sram_we_n", {63'd0, sram_we_n}, {63'd0, exp_we_n});
            chk("rd_pending", {61'd0, rd_pending}, 64'(pend_m));
            if (data_oe_n === 1'b0) begin
                if (exp_wr_q.size() == 0) begin
                    chk("wr_unexpected", {63'd0, data_oe_n}, 64'd1);
                end else begin
                    chk("wr_edge", 64'(edge_n), 64'(exp_wr_edge_q.pop_front()));
                    last_dout = exp_wr_q.pop_front();
                    chk("wr_data", {28'd0, data_out}, {28'd0, last_dout});
                end
            end else begin
                chk("dout_hold", {28'd0, data_out}, {28'd0, last_dout});
            end
            if (rd_valid === 1'b1) begin
                if (exp_rd_q.size() == 0) begin
                    chk("rd_unexpected", {63'd0, rd_valid}, 64'd0);
                end else begin
                    chk("rd_edge", 64'(edge_n), 64'(exp_rd_edge_q.pop_front()));
                    last_rd = exp_rd_q.pop_front();
                    chk("rd_data", {28'd0, rd_data}, {28'd0, last_rd});
                    chk("par_err", {63'd0, par_err}, {63'd0, exp_pe_q.pop_front()});
                end
            end else begin
                chk("rd_hold", {28'd0, rd_data}, {28'd0, last_rd});
                chk("rd_valid", {63'd0, rd_valid}, 64'd0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_we    = 1'b0;
        end
    endtask

    task automatic do_write(input logic [W-1:0] d, input int addr, input logic [W-1:0] exp);
        int e0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        wr_data   = d;
        e0 = edge_n + 1;
        if (rst_n) begin
            exp_wr_q.push_back(exp);
            exp_wr_edge_q.push_back(e0 + 2);
            wr_addr_q.push_back(addr);
        end
    endtask

    task automatic do_read(input int addr, input logic [W-1:0] exp, input logic [W-1:0] flip);
        int e0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        e0 = edge_n + 1;
        if (rst_n) begin
            rd_addr_at[e0 + 4] = addr;
            rd_flip_at[e0 + 4] = flip;
            ret_due[e0 + 4]    = 1'b1;
            exp_rd_q.push_back(exp);
            exp_rd_edge_q.push_back(e0 + 4);
            exp_pe_q.push_back(lane_bad(exp));
        end
    endtask

    logic [W-1:0] wvec[8] = '{36'h000000001, 36'hFFFFFFFFF, 36'h5A5A5A5A5, 36'hA5A5A5A5A,
                              36'h123456789, 36'h876543210, 36'h0F0F0F0F0, 36'hF00000001};

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        wr_data   = '0;
        data_in   = '0;
        mem[100]  = 36'hABCDE0123;
        for (int a = 0; a < 8; a++) mem[a] = W'(a);

        repeat (2) @(posedge clk);
        mon_en = 1;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        chk("reset_par_err", {63'd0, par_err}, 64'd0);

        // Single write, then single read of a preloaded word.
        do_write(36'h123456789, 200, exp_store(36'h123456789));
        idle(4);
        do_read(100, 36'hABCDE0123, '0);
        idle(6);

        // Eight back-to-back reads returning their address.
        for (int a = 0; a < 8; a++) do_read(a, W'(a), '0);
        idle(6);

        // Alternating write/read at full rate, each read fetching the word just written.
        for (int k = 0; k < 8; k++) begin
            do_write(wvec[k], 300 + k, exp_store(wvec[k]));
            do_read(300 + k, exp_store(wvec[k]), '0);
        end
        idle(6);

        // Reset lands while three reads and a write are still in flight.
        do_read(1, 36'd1, '0);
        do_read(2, 36'd2, '0);
        do_read(3, 36'd3, '0);
        do_write(36'h777777777, 500, 36'h777777777);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        do_write(36'h111111111, 501, 36'h111111111);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        idle(8);
        chk("post_reset_pending", {61'd0, rd_pending}, 64'd0);
        chk("post_reset_oe_n", {63'd0, data_oe_n}, 64'd1);
        do_read(5, 36'd5, '0);
        idle(6);

        // Parity generation on write, then a corrupted lane on read-back.
`ifdef ZBT_PARITY_EN
        do_write(36'h000000001, 400, 36'h000000101);
        idle(3);
        do_read(400, 36'h000100101, 36'h000100000);
`else
        do_write(36'h000000001, 400, 36'h000000001);
        idle(3);
        do_read(400, 36'h000100001, 36'h000100000);
`endif
        idle(8);

        chk("wr_drain", 64'(exp_wr_q.size()), 64'd0);
        chk("rd_drain", 64'(exp_rd_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
